// File: rtl/vmul_elem_sequencer.sv
// rtl/vmul_elem_sequencer.sv - element-serial vector multiply over one shared vedic multiplier
// Optional signed support: define VMUL_SEQ_SIGNED_EN.

module vedic_mul_unsigned #(
   parameter int         WIDTH                = 8,
   parameter int         MIN_MUL_LEVEL        = 4,
   parameter logic [1:0] MUL_IDX              = 2'b00,
   parameter bit         GET_MID_PREV_RESULTS = 1'b0
) (
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] result,
   output logic [2*WIDTH-1:0] prev_result
);
   generate
      if (WIDTH <= MIN_MUL_LEVEL) begin : g_leaf
         assign result      = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
         assign prev_result = '0;
      end else begin : g_split
         localparam int H = WIDTH / 2;
         logic [WIDTH-1:0]   p_ll, p_lh, p_hl, p_hh;
         logic [2*WIDTH-1:0] mid;
         vedic_mul_unsigned #(.WIDTH(H), .MIN_MUL_LEVEL(MIN_MUL_LEVEL), .MUL_IDX(2'b00), .GET_MID_PREV_RESULTS(1'b0))
            u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .result(p_ll), .prev_result());
         vedic_mul_unsigned #(.WIDTH(H), .MIN_MUL_LEVEL(MIN_MUL_LEVEL), .MUL_IDX(2'b01), .GET_MID_PREV_RESULTS(1'b0))
            u_lh (.a(a[H-1:0]), .b(b[WIDTH-1:H]), .result(p_lh), .prev_result());
         vedic_mul_unsigned #(.WIDTH(H), .MIN_MUL_LEVEL(MIN_MUL_LEVEL), .MUL_IDX(2'b10), .GET_MID_PREV_RESULTS(1'b0))
            u_hl (.a(a[WIDTH-1:H]), .b(b[H-1:0]), .result(p_hl), .prev_result());
         vedic_mul_unsigned #(.WIDTH(H), .MIN_MUL_LEVEL(MIN_MUL_LEVEL), .MUL_IDX(2'b11), .GET_MID_PREV_RESULTS(1'b0))
            u_hh (.a(a[WIDTH-1:H]), .b(b[WIDTH-1:H]), .result(p_hh), .prev_result());
         assign mid         = {{H{1'b0}}, p_lh, {H{1'b0}}} + {{H{1'b0}}, p_hl, {H{1'b0}}};
         assign result      = {p_hh, p_ll} + mid;
         assign prev_result = GET_MID_PREV_RESULTS ? mid : '0;
      end
   endgenerate
endmodule

module vmul_elem_sequencer #(
   parameter int VLEN          = 64,
   parameter int ELEM_WIDTH    = 8,
   parameter int MIN_MUL_LEVEL = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [VLEN-1:0] req_srca,
   input  logic [VLEN-1:0] req_srcb,
   input  logic            req_high,
   input  logic            req_signed,
   input  logic            flush,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [VLEN-1:0] resp_result,
   output logic            busy
);
   localparam int NUM_ELEMS = VLEN / ELEM_WIDTH;
   localparam int CNT_W     = $clog2(NUM_ELEMS) + 1;
   localparam int IDX_W     = CNT_W - 1;
   localparam int EW        = ELEM_WIDTH;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_ELEMS - 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_RESP} state_t;
   state_t state;

   logic [VLEN-1:0]   src_a, src_b;
   logic              high_q, signed_q, s1_valid, neg_q, issue_neg;
   logic [CNT_W-1:0]  issue_cnt, wb_cnt;
   logic [EW-1:0]     op_a, op_b, elem_a, elem_b, mag_a, mag_b, sel;
   logic [2*EW-1:0]   prod, prod_fix;
   logic [IDX_W-1:0]  issue_idx, wb_idx;

   assign issue_idx = issue_cnt[IDX_W-1:0];
   assign wb_idx    = wb_cnt[IDX_W-1:0];
   assign elem_a    = src_a[int'(issue_idx)*EW +: EW];
   assign elem_b    = src_b[int'(issue_idx)*EW +: EW];

`ifdef VMUL_SEQ_SIGNED_EN
   logic sign_a, sign_b;
   assign sign_a    = signed_q & elem_a[EW-1];
   assign sign_b    = signed_q & elem_b[EW-1];
   // Magnitude of the most-negative value is exact as an unsigned EW-bit number.
   assign mag_a     = sign_a ? -elem_a : elem_a;
   assign mag_b     = sign_b ? -elem_b : elem_b;
   assign issue_neg = sign_a ^ sign_b;
   assign prod_fix  = neg_q ? -prod : prod;
`else
   logic unused_signed;
   assign unused_signed = signed_q ^ neg_q;
   assign mag_a     = elem_a;
   assign mag_b     = elem_b;
   assign issue_neg = 1'b0;
   assign prod_fix  = prod;
`endif

   assign sel = high_q ? prod_fix[2*EW-1:EW] : prod_fix[EW-1:0];

   vedic_mul_unsigned #(
      .WIDTH(ELEM_WIDTH), .MIN_MUL_LEVEL(MIN_MUL_LEVEL), .MUL_IDX(2'b00), .GET_MID_PREV_RESULTS(1'b0)
   ) u_mul (
      .a(op_a), .b(op_b), .result(prod), .prev_result()
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         req_ready   <= 1'b1;
         busy        <= 1'b0;
         resp_valid  <= 1'b0;
         resp_result <= '0;
         src_a       <= '0;
         src_b       <= '0;
         high_q      <= 1'b0;
         signed_q    <= 1'b0;
         issue_cnt   <= '0;
         wb_cnt      <= '0;
         s1_valid    <= 1'b0;
         op_a        <= '0;
         op_b        <= '0;
         neg_q       <= 1'b0;
      end else if (flush) begin
         state       <= S_IDLE;
         req_ready   <= 1'b1;
         busy        <= 1'b0;
         resp_valid  <= 1'b0;
         resp_result <= '0;
         s1_valid    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (req_valid && req_ready) begin
               src_a       <= req_srca;
               src_b       <= req_srcb;
               high_q      <= req_high;
               signed_q    <= req_signed;
               resp_result <= '0;
               issue_cnt   <= '0;
               wb_cnt      <= '0;
               req_ready   <= 1'b0;
               busy        <= 1'b1;
               state       <= S_ISSUE;
            end
            S_ISSUE: begin
               op_a      <= mag_a;
               op_b      <= mag_b;
               neg_q     <= issue_neg;
               s1_valid  <= 1'b1;
               issue_cnt <= issue_cnt + CNT_W'(1);
               if (issue_cnt == LAST) state <= S_DRAIN;
            end
            S_DRAIN: s1_valid <= 1'b0;
            S_RESP: if (resp_ready) begin
               resp_valid <= 1'b0;
               req_ready  <= 1'b1;
               busy       <= 1'b0;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
         // Writeback runs one cycle behind issue, overlapping ISSUE and DRAIN.
         if (s1_valid) begin
            resp_result[int'(wb_idx)*EW +: EW] <= sel;
            wb_cnt <= wb_cnt + CNT_W'(1);
            if (wb_cnt == LAST) begin
               resp_valid <= 1'b1;
               state      <= S_RESP;
            end
         end
      end
   end
endmodule

// File: tb/tb_vmul_elem_sequencer.sv
// tb/tb_vmul_elem_sequencer.sv - directed self-checking bench for vmul_elem_sequencer

module tb_vmul_elem_sequencer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_ready, req_high = 1'b0, req_signed = 1'b0, flush = 1'b0;
   logic [63:0] req_srca = '0, req_srcb = '0, resp_result;
   logic        resp_valid, resp_ready = 1'b0, busy;
   int          compared = 0, mismatched = 0;

   vmul_elem_sequencer dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_srca(req_srca), .req_srcb(req_srcb), .req_high(req_high), .req_signed(req_signed),
      .flush(flush), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_result(resp_result), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic run(input logic [63:0] a, input logic [63:0] b, input logic hi, input logic sg,
                      input logic [63:0] expv, input int hold, input string tag);
      int n;
      @(negedge clk);
      req_srca = a; req_srcb = b; req_high = hi; req_signed = sg; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check({tag, "_busy"}, {63'd0, busy}, 64'd1);
      check({tag, "_rdy_low"}, {63'd0, req_ready}, 64'd0);
      n = 0;
      while (!resp_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_latency"}, 64'(n), 64'd9);
      check({tag, "_result"}, resp_result, expv);
      if (hold > 0) begin
         req_valid = 1'b1;
         repeat (hold) begin @(posedge clk); #1; end
         check({tag, "_hold_valid"}, {63'd0, resp_valid}, 64'd1);
         check({tag, "_hold_result"}, resp_result, expv);
         check({tag, "_hold_rdy"}, {63'd0, req_ready}, 64'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0; resp_ready = 1'b0;
      check({tag, "_rdy_back"}, {63'd0, req_ready}, 64'd1);
      check({tag, "_valid_off"}, {63'd0, resp_valid}, 64'd0);
      check({tag, "_idle"}, {63'd0, busy}, 64'd0);
   endtask

   initial begin
      logic [63:0] exp_sh, exp_sl;
      int          seen;
`ifdef VMUL_SEQ_SIGNED_EN
      exp_sh = 64'hFFFF_FFFF_FFFF_FFFF;
`else
      exp_sh = 64'h0101_0101_0101_0101;
`endif
      exp_sl = 64'hFEFE_FEFE_FEFE_FEFE;

      #12;
      check("rst_ready", {63'd0, req_ready}, 64'd1);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_valid", {63'd0, resp_valid}, 64'd0);
      check("rst_result", resp_result, 64'd0);
      @(negedge clk); rst = 1'b0;

      run(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 64'h0101_0101_0101_0101, 0, "ff_lo");
      run(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 64'hFEFE_FEFE_FEFE_FEFE, 0, "ff_hi");
      run(64'h0807_0605_0403_0201, 64'h0303_0303_0303_0303, 1'b0, 1'b0, 64'h1815_120F_0C09_0603, 0, "ramp");
      run(64'h0807_0605_0403_0201, 64'h4040_4040_4040_4040, 1'b1, 1'b0, 64'h0201_0101_0100_0000, 5, "stall");

      // flush together with a request in IDLE must not accept it
      @(negedge clk);
      req_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0; flush = 1'b0;
      check("flush_req_busy", {63'd0, busy}, 64'd0);
      check("flush_req_rdy", {63'd0, req_ready}, 64'd1);

      // flush during the 4th issue cycle
      @(negedge clk);
      req_srca = 64'h1111_1111_1111_1111; req_srcb = 64'h2222_2222_2222_2222; req_high = 1'b0; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_busy", {63'd0, busy}, 64'd0);
      check("flush_rdy", {63'd0, req_ready}, 64'd1);
      check("flush_result", resp_result, 64'd0);
      seen = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (resp_valid) seen++;
      end
      check("flush_no_resp", 64'(seen), 64'd0);
      run(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 64'h0101_0101_0101_0101, 0, "post_flush");

      // asynchronous reset in the middle of DRAIN
      @(negedge clk);
      req_srca = 64'h0807_0605_0403_0201; req_srcb = 64'h0303_0303_0303_0303; req_high = 1'b0; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (8) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("arst_busy", {63'd0, busy}, 64'd0);
      check("arst_valid", {63'd0, resp_valid}, 64'd0);
      check("arst_result", resp_result, 64'd0);
      check("arst_rdy", {63'd0, req_ready}, 64'd1);
      @(negedge clk); rst = 1'b0;
      run(64'h8080_8080_8080_8080, 64'h8080_8080_8080_8080, 1'b1, 1'b0, 64'h4040_4040_4040_4040, 0, "post_rst");

      run(64'hFFFF_FFFF_FFFF_FFFF, 64'h0202_0202_0202_0202, 1'b1, 1'b1, exp_sh, 0, "sgn_hi");
      run(64'hFFFF_FFFF_FFFF_FFFF, 64'h0202_0202_0202_0202, 1'b0, 1'b1, exp_sl, 0, "sgn_lo");
      run(64'h8080_8080_8080_8080, 64'h8080_8080_8080_8080, 1'b1, 1'b1, 64'h4040_4040_4040_4040, 0, "sgn_min");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
